ps2_scan_controller: RTL and testbench
======================================

Name: ps2_scan_controller

Overview:
Sequences the PS/2 byte receiver and turns its raw byte stream into complete key events. It handles the E0 (extended), F0 (break) and E1 (Pause) prefixes, and filters keyboard status bytes. It holds each finished event until the consumer acknowledges it, and throttles the receiver through rx_en while an event is pending. It sits between the PS/2 receiver and the application logic (display/control FSM).

Parameters:
TIMEOUT_CYCLES, 200000, clk cycles allowed between bytes of one multi-byte sequence (2 ms at 100 MHz)
TO_W, 18, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (reset==0 resets on the clk rising edge)
rx_done_tick  in  1  one-cycle pulse from the receiver: a byte is valid on rx_data
rx_data  in  8  received scan byte
rx_en  out  1  enables the receiver to start a new frame
key_valid  out  1  event pending; held until acknowledged
key_code  out  8  final scan code of the event
key_ext  out  1  event was E0-prefixed
key_break  out  1  event was a release (F0-prefixed)
key_ack  in  1  consumer accepts the pending event
overrun  out  1  sticky: a byte arrived while an event was pending and was dropped

Behaviour:
- Reset (reset==0): state=IDLE, rx_en=0 during reset, key_valid=0, key_code=0, key_ext=0, key_break=0, overrun=0, prefix flags=0, timeout counter=0, skip counter=0.
- rx_en=1 in every state except HOLD and reset.
- Registered outputs. key_valid rises on the clk edge after the rx_done_tick that completes the event (1-cycle latency).
- States:
  - IDLE: on a tick:
    - E0 -> set ext, go to PREFIX.
    - F0 -> set brk, go to PREFIX.
    - E1 -> skip_cnt=7, go to SKIP.
    - AA, FA, FE, EE, 00, FF -> discard, stay in IDLE.
    - Any other byte -> latch the code with ext=0 and brk=0, go to HOLD.
  - PREFIX: on a tick:
    - F0 -> set brk, stay.
    - E0 -> set ext, stay.
    - Other byte -> latch the code with the accumulated ext/brk, clear the flags, go to HOLD.
  - SKIP: each tick decrements skip_cnt. On the tick seen with skip_cnt==1: latch key_code=E1, ext=0, brk=0, go to HOLD. The 7 trailing Pause bytes are never decoded.
  - HOLD: key_valid=1.
    - key_ack=1 -> key_valid=0, overrun cleared, go to IDLE on the next edge.
    - A tick in HOLD -> byte dropped, overrun=1. If ack and tick coincide, the byte is dropped but overrun is still cleared by the ack; the cleared state wins.
- Timeout: the counter runs only in PREFIX and SKIP and resets to 0 on every tick. Reaching TIMEOUT_CYCLES-1 clears the flags and skip_cnt and returns to IDLE; no event is emitted. A tick in the same cycle as expiry is processed normally and the timeout is ignored.
- key_ack while key_valid=0 is ignored.
- Outputs key_code/ext/break stay stable from key_valid rise until ack; they keep their last value afterwards.
- Reset mid-sequence discards all partial state. No event is emitted.

Decomposition:
- Shared package: state encoding (IDLE, PREFIX, SKIP, HOLD), byte constants (E0, F0, E1, and the status bytes AA/FA/FE/EE/00/FF), and the Pause byte count 7.
- One natural sub-module: ps2_seq_timeout. It holds the clearable down-counter with start/clear/expire signals, parameterised by TIMEOUT_CYCLES/TO_W.
- Everything else lives in a single FSM with datapath registers.

Test Plan:
1. Tick 1C, ack 3 cycles later -> key_valid=1 one cycle after the tick, code=1C, ext=0, brk=0, rx_en=0 until the ack, then rx_en=1 and key_valid=0.
2. Ticks E0, F0, 75 -> single event code=75, ext=1, brk=1. Ticks F0, 1C -> code=1C, ext=0, brk=1. No event after the prefix bytes alone.
3. Ticks E1 14 77 E1 F0 14 F0 77 -> exactly one event, code=E1, ext=0, brk=0, emitted after the 8th byte.
4. Ticks AA then FA -> no event, state IDLE. Tick E0, then a gap of TIMEOUT_CYCLES with no tick, then 1C -> one event code=1C, ext=0 (prefix expired).
5. Tick 1C (HOLD), then tick 32 before the ack -> overrun=1, code still 1C. Ack -> overrun=0. The 32 is never reported.
6. Tick F0, then reset low for 1 cycle, then tick 1C -> event code=1C, brk=0. Ack and tick in the same cycle in HOLD -> overrun=0, state IDLE, byte dropped.

Source files
------------

// File: rtl/ps2_scan_controller_pkg.sv
// Shared types and constants for the PS/2 scan-code sequencer.
package ps2_scan_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PREFIX = 2'd1,
    ST_SKIP   = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;

  localparam logic [7:0] STAT_AA = 8'hAA;
  localparam logic [7:0] STAT_FA = 8'hFA;
  localparam logic [7:0] STAT_FE = 8'hFE;
  localparam logic [7:0] STAT_EE = 8'hEE;
  localparam logic [7:0] STAT_00 = 8'h00;
  localparam logic [7:0] STAT_FF = 8'hFF;

  // Bytes following E1 in the Pause make sequence
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  function automatic logic is_status(input logic [7:0] b);
    return (b == STAT_AA) || (b == STAT_FA) || (b == STAT_FE) ||
           (b == STAT_EE) || (b == STAT_00) || (b == STAT_FF);
  endfunction

endpackage

// File: rtl/ps2_scan_controller_if.sv
// Receiver-side and consumer-side signals of the scan controller.
interface ps2_scan_controller_if;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       rx_en;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_ack;
  logic       overrun;

  modport master (
    input  rx_done_tick, rx_data, key_ack,
    output rx_en, key_valid, key_code, key_ext, key_break, overrun
  );

  modport slave (
    output rx_done_tick, rx_data, key_ack,
    input  rx_en, key_valid, key_code, key_ext, key_break, overrun
  );
endinterface

// File: rtl/ps2_seq_timeout.sv
// Inter-byte timeout for multi-byte sequences: down-counter reloaded on every
// byte (or whenever not armed), expiring at terminal count.
module ps2_seq_timeout #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int TO_W           = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expire
);

  localparam logic [TO_W-1:0] LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clear || !i_run) begin
      r_cnt <= LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A byte in the expiry cycle wins over the timeout
  assign o_expire = i_run && !i_clear && (r_cnt == '0);

endmodule

// File: rtl/ps2_scan_controller.sv
// Assembles PS/2 scan bytes into key events and holds each until acknowledged.
//
//   state  | meaning
//   IDLE   | waiting for the first byte of a sequence
//   PREFIX | E0 and/or F0 seen, waiting for the final code byte
//   SKIP   | consuming the trailing bytes of the E1 Pause sequence
//   HOLD   | event pending, receiver throttled until key_ack
module ps2_scan_controller
  import ps2_scan_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int TO_W           = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  ps2_scan_controller_if.master   bus
);

  state_t     r_state, w_state_nxt;
  logic       r_ext, w_ext_nxt;
  logic       r_brk, w_brk_nxt;
  logic [2:0] r_skip_cnt, w_skip_nxt;
  logic       r_key_valid, w_valid_nxt;
  logic [7:0] r_key_code, w_code_nxt;
  logic       r_key_ext, w_kext_nxt;
  logic       r_key_break, w_kbrk_nxt;
  logic       r_overrun, w_ovr_nxt;
  logic       r_rx_en;

  logic       w_tick;
  logic [7:0] w_data;
  logic       w_run;
  logic       w_expire;

  assign w_tick = bus.rx_done_tick;
  assign w_data = bus.rx_data;
  assign w_run  = (r_state == ST_PREFIX) || (r_state == ST_SKIP);

  ps2_seq_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_run    (w_run),
    .i_clear  (w_tick),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_skip_cnt  <= '0;
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
      r_key_ext   <= 1'b0;
      r_key_break <= 1'b0;
      r_overrun   <= 1'b0;
      r_rx_en     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ext       <= w_ext_nxt;
      r_brk       <= w_brk_nxt;
      r_skip_cnt  <= w_skip_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_code  <= w_code_nxt;
      r_key_ext   <= w_kext_nxt;
      r_key_break <= w_kbrk_nxt;
      r_overrun   <= w_ovr_nxt;
      r_rx_en     <= (w_state_nxt != ST_HOLD);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ext_nxt   = r_ext;
    w_brk_nxt   = r_brk;
    w_skip_nxt  = r_skip_cnt;
    w_valid_nxt = r_key_valid;
    w_code_nxt  = r_key_code;
    w_kext_nxt  = r_key_ext;
    w_kbrk_nxt  = r_key_break;
    w_ovr_nxt   = r_overrun;

    case (r_state)
      ST_IDLE: begin
        if (w_tick) begin
          if (w_data == BYTE_E0) begin
            w_ext_nxt   = 1'b1;
            w_state_nxt = ST_PREFIX;
          end else if (w_data == BYTE_F0) begin
            w_brk_nxt   = 1'b1;
            w_state_nxt = ST_PREFIX;
          end else if (w_data == BYTE_E1) begin
            w_skip_nxt  = PAUSE_SKIP;
            w_state_nxt = ST_SKIP;
          end else if (!is_status(w_data)) begin
            w_code_nxt  = w_data;
            w_kext_nxt  = 1'b0;
            w_kbrk_nxt  = 1'b0;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end
      end

      ST_PREFIX: begin
        if (w_tick) begin
          if (w_data == BYTE_F0) begin
            w_brk_nxt = 1'b1;
          end else if (w_data == BYTE_E0) begin
            w_ext_nxt = 1'b1;
          end else begin
            w_code_nxt  = w_data;
            w_kext_nxt  = r_ext;
            w_kbrk_nxt  = r_brk;
            w_ext_nxt   = 1'b0;
            w_brk_nxt   = 1'b0;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end else if (w_expire) begin
          w_ext_nxt   = 1'b0;
          w_brk_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_SKIP: begin
        if (w_tick) begin
          if (r_skip_cnt == 3'd1) begin
            w_skip_nxt  = '0;
            w_code_nxt  = BYTE_E1;
            w_kext_nxt  = 1'b0;
            w_kbrk_nxt  = 1'b0;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_HOLD;
          end else begin
            w_skip_nxt = r_skip_cnt - 3'd1;
          end
        end else if (w_expire) begin
          w_skip_nxt  = '0;
          w_ext_nxt   = 1'b0;
          w_brk_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_HOLD: begin
        // Ack takes priority over a coincident dropped byte
        if (bus.key_ack) begin
          w_valid_nxt = 1'b0;
          w_ovr_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end else if (w_tick) begin
          w_ovr_nxt = 1'b1;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.rx_en     = r_rx_en;
  assign bus.key_valid = r_key_valid;
  assign bus.key_code  = r_key_code;
  assign bus.key_ext   = r_key_ext;
  assign bus.key_break = r_key_break;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_ps2_scan_controller.sv
// Checks the scan controller against a byte-sequence reference model under
// directed scenarios and randomized byte/ack/reset traffic.
module tb_ps2_scan_controller;

  localparam int T = 40;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ps2_scan_controller_if bus();

  ps2_scan_controller #(
    .TIMEOUT_CYCLES (T),
    .TO_W           (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: bytes of the sequence in progress plus the held event
  logic [7:0] m_seq[$];
  int         m_gap   = 0;
  bit         m_valid = 0;
  bit         m_ovr   = 0;
  bit         m_rxen  = 0;
  logic [7:0] m_code  = '0;
  bit         m_ext   = 0;
  bit         m_brk   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic bit is_stat(input logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  endfunction

  task automatic emit(input logic [7:0] code, input bit ext, input bit brk);
    m_valid = 1;
    m_code  = code;
    m_ext   = ext;
    m_brk   = brk;
    m_seq.delete();
    m_gap   = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit ext, brk;
    m_seq.push_back(b);
    if (m_seq[0] == 8'hE1) begin
      if (m_seq.size() == 8) emit(8'hE1, 0, 0);
    end else if (m_seq.size() == 1 && is_stat(b)) begin
      m_seq.delete();
    end else if (b != 8'hE0 && b != 8'hF0) begin
      ext = 0;
      brk = 0;
      foreach (m_seq[i]) begin
        if (m_seq[i] == 8'hE0) ext = 1;
        if (m_seq[i] == 8'hF0) brk = 1;
      end
      emit(b, ext, brk);
    end
  endtask

  task automatic step(input bit tick, input logic [7:0] data, input bit ack, input bit rst_n);
    @(negedge clk);
    bus.rx_done_tick = tick;
    bus.rx_data      = data;
    bus.key_ack      = ack;
    reset            = rst_n;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_seq.delete();
      m_gap = 0; m_valid = 0; m_ovr = 0; m_rxen = 0;
      m_code = '0; m_ext = 0; m_brk = 0;
    end else begin
      if (m_valid) begin
        if (ack) begin
          m_valid = 0;
          m_ovr   = 0;
        end else if (tick) begin
          m_ovr = 1;
        end
      end else if (tick) begin
        m_gap = 0;
        model_byte(data);
      end else if (m_seq.size() > 0) begin
        m_gap++;
        if (m_gap == T) begin
          m_seq.delete();
          m_gap = 0;
        end
      end
      m_rxen = !m_valid;
    end
    chk("rx_en",     bus.rx_en,     m_rxen);
    chk("key_valid", bus.key_valid, m_valid);
    chk("key_code",  bus.key_code,  m_code);
    chk("key_ext",   bus.key_ext,   m_ext);
    chk("key_break", bus.key_break, m_brk);
    chk("overrun",   bus.overrun,   m_ovr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 1);
  endtask

  task automatic tick_b(input logic [7:0] b);
    step(1, b, 0, 1);
  endtask

  task automatic ack1();
    step(0, 8'h00, 1, 1);
  endtask

  logic [7:0] pause_seq[8];
  logic [7:0] stat_pool[6];

  initial begin
    bus.rx_done_tick = 0;
    bus.rx_data      = '0;
    bus.key_ack      = 0;
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    stat_pool = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

    // Reset state
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("reset_rx_en", bus.rx_en, 1'b0);
    idle(2);

    // Single make code, ack three cycles later
    tick_b(8'h1C);
    chk("t1_valid", bus.key_valid, 1'b1);
    chk("t1_code",  bus.key_code,  8'h1C);
    idle(2);
    chk("t1_rx_en_held", bus.rx_en, 1'b0);
    ack1();
    chk("t1_rx_en_after", bus.rx_en, 1'b1);
    idle(2);

    // Extended break, then plain break; nothing after prefixes alone
    tick_b(8'hE0); tick_b(8'hF0);
    chk("t2_no_early", bus.key_valid, 1'b0);
    tick_b(8'h75);
    chk("t2_ext", bus.key_ext, 1'b1);
    chk("t2_brk", bus.key_break, 1'b1);
    idle(1); ack1();
    tick_b(8'hF0); tick_b(8'h1C);
    idle(1); ack1();

    // Pause sequence yields one E1 event after the eighth byte
    for (int i = 0; i < 8; i++) begin
      tick_b(pause_seq[i]);
      if (i < 7) idle(1);
    end
    chk("t3_code", bus.key_code, 8'hE1);
    ack1(); idle(2);

    // Status bytes filtered; prefix expires exactly at the timeout gap
    tick_b(8'hAA); tick_b(8'hFA);
    tick_b(8'hE0); idle(T); tick_b(8'h1C);
    chk("t4_ext_expired", bus.key_ext, 1'b0);
    ack1();
    tick_b(8'hE0); idle(T - 1); tick_b(8'h1C);
    chk("t4_ext_kept", bus.key_ext, 1'b1);
    ack1();

    // Overrun in HOLD, cleared by ack
    tick_b(8'h1C); tick_b(8'h32);
    chk("t5_ovr", bus.overrun, 1'b1);
    ack1(); idle(2);

    // Reset mid-sequence, then ack coinciding with a tick
    tick_b(8'hF0);
    step(0, 8'h00, 0, 0);
    tick_b(8'h1C);
    chk("t6_brk", bus.key_break, 1'b0);
    step(1, 8'h29, 1, 1);
    chk("t6_ovr", bus.overrun, 1'b0);
    idle(2);

    // Randomized traffic
    for (int it = 0; it < 3000; it++) begin
      int r;
      bit tk, ak, rn;
      logic [7:0] b;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        idle(int'($urandom_range(T - 3, T + 3)));
      end else begin
        tk = ($urandom_range(0, 99) < 35);
        ak = ($urandom_range(0, 99) < 25);
        rn = ($urandom_range(0, 199) != 0);
        case ($urandom_range(0, 9))
          0, 1: b = 8'hE0;
          2, 3: b = 8'hF0;
          4:    b = 8'hE1;
          5:    b = stat_pool[$urandom_range(0, 5)];
          default: b = 8'($urandom_range(0, 255));
        endcase
        step(tk, b, ak, rn);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
